// File: rtl/tiny32_io_timer.sv
// tiny32_io_timer: memory-mapped prescaled down-counting timer with interrupt on the tiny32 io bus
module tiny32_io_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0100,
  parameter int PRESCALER_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req,
  input  logic        io_nwr,
  input  logic [31:0] io_address,
  input  logic [31:0] io_data_in,
  output logic [31:0] io_data_out,
  output logic        io_ready,
  output logic        irq,
  input  logic        irq_ack
);
  logic en, auto_reload, ie, pend;
  logic [PRESCALER_BITS-1:0] prescale, pc;
  logic [31:0] reload, count, rdata;
  logic sel, acc, wr, wr_ctrl, wr_pre, wr_cnt, w1c, tick, expire;
  logic [1:0] idx;
  logic unused_addr;
  assign unused_addr = ^io_address[1:0];
  assign sel = io_req && io_address[31:4] == BASE_ADDRESS[31:4];
  assign acc = sel && !io_ready;
  assign wr = acc && !io_nwr;
  assign idx = io_address[3:2];
  assign wr_ctrl = wr && idx == 2'd0;
  assign wr_pre = wr && idx == 2'd1;
  assign wr_cnt = wr && idx == 2'd2;
  assign w1c = wr && idx == 2'd3 && io_data_in[0];
  assign tick = en && pc == prescale && !wr_cnt;
  assign expire = tick && count == 32'd0;
  assign irq = pend && ie;
  always_comb begin
    rdata = idx == 2'd0 ? {29'd0, ie, auto_reload, en} :
            idx == 2'd1 ? 32'(prescale) :
            idx == 2'd2 ? count : {31'd0, pend};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      io_ready <= 1'b0;
      io_data_out <= '0;
      en <= 1'b0;
      auto_reload <= 1'b0;
      ie <= 1'b0;
      prescale <= '0;
      reload <= '0;
      count <= '0;
      pc <= '0;
      pend <= 1'b0;
    end else begin
      io_ready <= acc;
      io_data_out <= acc && io_nwr ? rdata : '0;
      en <= wr_ctrl ? io_data_in[0] : en && !(expire && !auto_reload);
      auto_reload <= wr_ctrl ? io_data_in[1] : auto_reload;
      ie <= wr_ctrl ? io_data_in[2] : ie;
      prescale <= wr_pre ? io_data_in[PRESCALER_BITS-1:0] : prescale;
      reload <= wr_cnt ? io_data_in : reload;
      count <= wr_cnt ? io_data_in : !tick ? count : expire ? (auto_reload ? reload : '0) : count - 32'd1;
      pc <= (wr_cnt || !en || pc == prescale) ? '0 : pc + 1'b1;
      pend <= expire || (pend && !irq_ack && !w1c);
    end
  end
endmodule

// File: tb/tb_tiny32_io_timer.sv
// tb_tiny32_io_timer: randomized self-checking bench for the io-bus timer
module tb_tiny32_io_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic io_req = 1'b0;
  logic io_nwr = 1'b1;
  logic irq_ack = 1'b0;
  logic [31:0] io_address = '0;
  logic [31:0] io_data_in = '0;
  logic [31:0] io_data_out;
  logic io_ready, irq;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  tiny32_io_timer dut (
    .clk(clk), .reset(reset), .io_req(io_req), .io_nwr(io_nwr),
    .io_address(io_address), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .io_ready(io_ready), .irq(irq), .irq_ack(irq_ack)
  );
  task automatic io_rw(input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] q, output logic rdy);
    io_req = 1'b1; io_nwr = !w; io_address = a; io_data_in = d;
    @(posedge clk); #1;
    rdy = io_ready; q = io_data_out;
    io_req = 1'b0; io_nwr = 1'b1; io_address = '0; io_data_in = '0;
    @(posedge clk); #1;
  endtask
  task automatic wr_reg(input int r, input logic [31:0] d);
    logic [31:0] q;
    logic rdy;
    io_rw(1'b1, 32'h100 + 32'(4 * r), d, q, rdy);
  endtask
  task automatic rd_reg(input int r, output logic [31:0] q);
    logic rdy;
    io_rw(1'b0, 32'h100 + 32'(4 * r), '0, q, rdy);
  endtask
  task automatic wait_irq(output int n);
    n = 1;
    while (!irq && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic test_reset;
    logic [31:0] q;
    logic rdy;
    time t0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if (irq !== 1'b0 || io_ready !== 1'b0 || io_data_out !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: irq=%b ready=%b data=%h, want 0 0 0", irq, io_ready, io_data_out);
    end
    t0 = $time;
    for (int r = 0; r < 4; r++) begin
      io_rw(1'b0, 32'h100 + 32'(4 * r), '0, q, rdy);
      tests++;
      if (rdy !== 1'b1 || q !== 32'd0) begin
        fails++;
        $display("FAIL reset_read%0d: ready=%b data=%h, want 1 0", r, rdy, q);
      end
      tests++;
      if (io_ready !== 1'b0) begin
        fails++;
        $display("FAIL ready_pulse%0d: ready=%b, want 0", r, io_ready);
      end
    end
    tests++;
    if ($time - t0 !== 80) begin
      fails++;
      $display("FAIL throughput: %0t, want 80", $time - t0);
    end
  endtask
  task automatic test_regs;
    logic [31:0] c, p, n, q;
    for (int i = 0; i < 8; i++) begin
      c = $urandom & 32'hFFFF_FFFE;
      p = $urandom;
      n = $urandom;
      wr_reg(0, c);
      wr_reg(1, p);
      wr_reg(2, n);
      rd_reg(0, q);
      tests++;
      if (q !== (c & 32'h6)) begin
        fails++;
        $display("FAIL ctrl_rb: %h, want %h", q, c & 32'h6);
      end
      rd_reg(1, q);
      tests++;
      if (q !== (p & 32'hFFFF)) begin
        fails++;
        $display("FAIL prescale_rb: %h, want %h", q, p & 32'hFFFF);
      end
      rd_reg(2, q);
      tests++;
      if (q !== n) begin
        fails++;
        $display("FAIL count_rb: %h, want %h", q, n);
      end
      rd_reg(3, q);
      tests++;
      if (q !== 32'd0) begin
        fails++;
        $display("FAIL status_rb: %h, want 0", q);
      end
    end
    wr_reg(0, 0);
  endtask
  task automatic test_auto;
    int n;
    logic [31:0] q;
    wr_reg(0, 0);
    wr_reg(3, 1);
    wr_reg(1, 3);
    wr_reg(2, 4);
    wr_reg(0, 7);
    wait_irq(n);
    tests++;
    if (n != 20) begin
      fails++;
      $display("FAIL auto_first: %0d cycles, want 20", n);
    end
    for (int k = 0; k < 2; k++) begin
      irq_ack = 1'b1;
      @(posedge clk); #1;
      irq_ack = 1'b0;
      tests++;
      if (irq !== 1'b0) begin
        fails++;
        $display("FAIL ack_clear%0d: irq=%b, want 0", k, irq);
      end
      wait_irq(n);
      tests++;
      if (n != 20) begin
        fails++;
        $display("FAIL auto_period%0d: %0d cycles, want 20", k, n);
      end
    end
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL pre_collision: irq=%b, want 0", irq);
    end
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL collision: irq=%b, want 1", irq);
    end
    wr_reg(3, 1);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL w1c_irq: irq=%b, want 0", irq);
    end
    rd_reg(3, q);
    tests++;
    if (q !== 32'd0) begin
      fails++;
      $display("FAIL w1c_status: %h, want 0", q);
    end
    wr_reg(0, 0);
  endtask
  task automatic test_oneshot;
    int p, r, n;
    logic [31:0] q;
    for (int i = 0; i < 7; i++) begin
      p = i == 0 ? 0 : int'($urandom_range(3));
      r = i == 0 ? 2 : int'($urandom_range(5));
      wr_reg(0, 0);
      wr_reg(3, 1);
      wr_reg(1, 32'(p));
      wr_reg(2, 32'(r));
      wr_reg(0, 5);
      wait_irq(n);
      tests++;
      if (n != (p + 1) * (r + 1)) begin
        fails++;
        $display("FAIL oneshot_period p=%0d r=%0d: %0d cycles, want %0d", p, r, n, (p + 1) * (r + 1));
      end
      rd_reg(0, q);
      tests++;
      if (q !== 32'h4) begin
        fails++;
        $display("FAIL oneshot_ctrl: %h, want 4", q);
      end
      rd_reg(2, q);
      tests++;
      if (q !== 32'd0) begin
        fails++;
        $display("FAIL oneshot_count: %h, want 0", q);
      end
      wr_reg(3, 1);
      repeat (30) @(posedge clk);
      #1;
      rd_reg(3, q);
      tests++;
      if (q !== 32'd0 || irq !== 1'b0) begin
        fails++;
        $display("FAIL oneshot_rearm: status=%h irq=%b, want 0 0", q, irq);
      end
    end
    wr_reg(0, 0);
    wr_reg(3, 1);
  endtask
  task automatic test_back_to_back;
    logic [3:0] obs;
    logic [31:0] q;
    logic rdy;
    wr_reg(2, 0);
    io_req = 1'b1; io_nwr = 1'b0; io_address = 32'h108; io_data_in = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      obs[i] = io_ready;
      if (i == 2) begin
        io_req = 1'b0; io_nwr = 1'b1; io_address = '0; io_data_in = '0;
      end
    end
    tests++;
    if (obs !== 4'b0101) begin
      fails++;
      $display("FAIL held_req_ready: %b, want 0101", obs);
    end
    rd_reg(2, q);
    tests++;
    if (q !== 32'h10) begin
      fails++;
      $display("FAIL held_req_count: %h, want 10", q);
    end
    io_rw(1'b0, 32'h200, '0, q, rdy);
    tests++;
    if (rdy !== 1'b0 || q !== 32'd0 || io_ready !== 1'b0) begin
      fails++;
      $display("FAIL unselected_read: ready=%b data=%h, want 0 0", rdy, q);
    end
    io_rw(1'b1, 32'h110, 32'h55, q, rdy);
    rd_reg(2, q);
    tests++;
    if (rdy !== 1'b0 || q !== 32'h10) begin
      fails++;
      $display("FAIL unselected_write: ready=%b count=%h, want 0 10", rdy, q);
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] q;
    wr_reg(1, 0);
    wr_reg(2, 0);
    wr_reg(0, 7);
    wr_reg(1, 100);
    wr_reg(2, 7);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_irq: irq=%b, want 1", irq);
    end
    reset = 1'b1;
    io_req = 1'b1; io_nwr = 1'b0; io_address = 32'h100; io_data_in = 32'h7;
    @(posedge clk); #1;
    reset = 1'b0;
    io_req = 1'b0; io_nwr = 1'b1; io_address = '0; io_data_in = '0;
    tests++;
    if (io_ready !== 1'b0 || irq !== 1'b0 || io_data_out !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: ready=%b irq=%b data=%h, want 0 0 0", io_ready, irq, io_data_out);
    end
    @(posedge clk); #1;
    tests++;
    if (io_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_ready: ready=%b, want 0", io_ready);
    end
    for (int r = 0; r < 4; r++) begin
      rd_reg(r, q);
      tests++;
      if (q !== 32'd0) begin
        fails++;
        $display("FAIL reset_mid_reg%0d: %h, want 0", r, q);
      end
    end
  endtask
  initial begin
    test_reset;
    test_regs;
    test_auto;
    test_oneshot;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tiny32_io_timer.md
Name: tiny32_io_timer

Overview:
- Memory-mapped down-counting timer with interrupt request, attached as a slave on the tiny32 CPU io bus (io_req/io_nwr/io_address/io_data/io_ready).
- Consumes CPU io cycles and drives one line of the CPU `interrupt[7:0]` vector. It clears that line on the matching `interrupt_ack` bit.
- Read data is 0 when the block is not selected, so several peripherals OR-combine onto the CPU io_data_in.

Parameters:
- BASE_ADDRESS, 32'h0000_0100, io address of register 0; bits [3:0] must be zero.
- PRESCALER_BITS, 16, width of the prescaler register and prescaler counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- io_req  in  1  CPU io request, held until io_ready seen
- io_nwr  in  1  0 = write, 1 = read
- io_address  in  32  byte address
- io_data_in  in  32  write data from CPU
- io_data_out  out  32  read data to CPU; 0 unless io_ready is high for a read
- io_ready  out  1  one-cycle completion pulse
- irq  out  1  level interrupt request to CPU interrupt[n]
- irq_ack  in  1  CPU interrupt_ack[n]

Behaviour:
- Select: sel = io_req & (io_address[31:4] == BASE_ADDRESS[31:4]). Register index = io_address[3:2]. io_address[1:0] is ignored.
- Register map:
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - 1 PRESCALE: [PRESCALER_BITS-1:0].
  - 2 COUNT: write loads both reload and count; read returns the live count.
  - 3 STATUS: bit0 PEND; writing 1 to bit0 clears PEND.
- Handshake:
  - A cycle with sel=1 and io_ready=0 accepts the access.
  - The write takes effect at that edge.
  - On the next cycle io_ready=1 for exactly one cycle, with registered read data on io_data_out.
  - A cycle with io_ready=1 never accepts, so one held request executes once. io_req high on the following cycle is a new access; back-to-back throughput is one access per 2 cycles.
  - Unselected requests are ignored: io_ready stays 0 and io_data_out stays 0.
- Prescaler:
  - Counter pc counts 0..PRESCALE while EN=1.
  - When pc==PRESCALE, a tick is generated and pc returns to 0. PRESCALE=0 gives a tick every cycle.
  - EN=0 holds pc at 0.
- Counter, on each tick:
  - If count==0: PEND is set. If AUTO=1, count is reloaded from reload; otherwise EN is cleared and count stays 0.
  - Otherwise count is decremented by 1.
  - Period in ticks = reload+1. Unsigned 32-bit; there is no wrap below 0.
- A write to COUNT loads the count and resets pc to 0 in the same edge; any tick in that cycle is discarded.
- irq = PEND & IE, registered (it follows PEND with 0 extra latency because PEND is itself a flop).
- irq_ack=1 clears PEND. If a set and a clear (ack or W1C) happen in the same cycle, the set wins and PEND stays 1.
- Clearing IE masks irq but keeps PEND.
- Reset: CTRL=0, PRESCALE=0, reload=0, count=0, pc=0, PEND=0, irq=0, io_ready=0, io_data_out=0.
  - Reset mid-access aborts it: no ready pulse is issued and no write takes effect.

Test Plan:
- Reset, then read all 4 regs at 0x100..0x10C -> each read returns 0, io_ready pulses one cycle after the accepting cycle, 4 accesses in 8 cycles.
- Write PRESCALE=3, COUNT=4, CTRL=0x7 -> PEND and irq rise 20 cycles after the CTRL write edge ((3+1)*(4+1)). With AUTO set, irq persists and PEND re-asserts every 20 cycles after each ack.
- One-shot: CTRL=0x5, COUNT=2, PRESCALE=0 -> PEND after 3 cycles. CTRL reads 0x4 afterwards, count stays 0, and no further PEND occurs after a W1C to STATUS.
- Collision: align irq_ack=1 with the tick where count==0 -> PEND stays 1. A separate W1C to STATUS clears PEND and drops irq the next cycle.
- io_req held 3 cycles at 0x108 with a write of 0x10 -> exactly two writes execute (accept cycles 0 and 2). An access to address 0x200 gets no io_ready and io_data_out=0.
- Assert reset while count=7 and EN=1 -> next cycle all registers are 0, irq=0, and an access accepted in the reset cycle produces no io_ready.
